// File: rtl/lvds_pkg.sv
// Shared panel timing, image geometry and scan FSM encoding for the LVDS image path.
// The image RAM uses the IMG_* constants, so keep both sides in step when changing them.
package lvds_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 48;
    localparam int H_BP     = 40;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 13;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 29;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int IMG_W     = 200;
    localparam int IMG_H     = 200;
    localparam int IMG_DEPTH = IMG_W * IMG_H;
    localparam int RAM_LAT   = 1;

    // Coordinate width covers any total up to 2047; address width covers a 64K-word RAM.
    localparam int CW = 11;
    localparam int AW = 16;

    localparam logic [1:0] EN_READ = 2'b01;
    localparam logic [1:0] EN_HOLD = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } scan_state_t;

    function automatic logic [CW-1:0] clamp_coord(input logic [CW-1:0] c, input logic [CW-1:0] lim);
        return (c > lim) ? lim : c;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register used to line control signals up with registered RAM data.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clkq,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/img_scan_ctrl.sv
// Panel timing generator that places the image window and sequences image RAM reads.
// state    | meaning
// IDLE     | counters parked at 0,0, nothing scanned
// RUN      | scanning, another frame follows this one
// STOPPING | scanning, return to IDLE after the last pixel
module img_scan_ctrl #(
    parameter int H_ACTIVE = lvds_pkg::H_ACTIVE,
    parameter int H_FP     = lvds_pkg::H_FP,
    parameter int H_SYNC   = lvds_pkg::H_SYNC,
    parameter int H_BP     = lvds_pkg::H_BP,
    parameter int V_ACTIVE = lvds_pkg::V_ACTIVE,
    parameter int V_FP     = lvds_pkg::V_FP,
    parameter int V_SYNC   = lvds_pkg::V_SYNC,
    parameter int V_BP     = lvds_pkg::V_BP,
    parameter int IMG_W    = lvds_pkg::IMG_W,
    parameter int IMG_H    = lvds_pkg::IMG_H,
    parameter int RAM_LAT  = lvds_pkg::RAM_LAT
) (
    input  logic        clkq,
    input  logic        rstn,
    input  logic        run,
    input  logic [9:0]  win_x,
    input  logic [9:0]  win_y,
    output logic [15:0] addrX,
    output logic [1:0]  en,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_valid,
    output logic        frame_start
);
    import lvds_pkg::*;

    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] X_MAX  = CW'(H_ACTIVE - IMG_W);
    localparam logic [CW-1:0] Y_MAX  = CW'(V_ACTIVE - IMG_H);
    localparam logic [CW-1:0] WIN_W  = CW'(IMG_W);
    localparam logic [CW-1:0] WIN_H  = CW'(IMG_H);

    scan_state_t   state;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic [AW-1:0] addr_cnt;
    logic          scanning;
    logic          last_pix;
    logic          de0;
    logic          hs0;
    logic          vs0;
    logic          in_win0;
    logic [3:0]    aligned;

    assign scanning = (state != ST_IDLE);
    assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign de0      = scanning && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs0      = scanning && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs0      = scanning && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign in_win0  = scanning && (h_cnt >= sx) && (h_cnt < sx + WIN_W)
                               && (v_cnt >= sy) && (v_cnt < sy + WIN_H);

    always_ff @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            sx          <= '0;
            sy          <= '0;
            addr_cnt    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state       <= ST_RUN;
                        frame_start <= 1'b1;
                        sx          <= clamp_coord(CW'(win_x), X_MAX);
                        sy          <= clamp_coord(CW'(win_y), Y_MAX);
                    end
                end
                default: begin
                    if (last_pix) begin
                        // Window is only re-sampled here so it never moves mid-frame.
                        h_cnt    <= '0;
                        v_cnt    <= '0;
                        addr_cnt <= '0;
                        sx       <= clamp_coord(CW'(win_x), X_MAX);
                        sy       <= clamp_coord(CW'(win_y), Y_MAX);
                        if (run) begin
                            state       <= ST_RUN;
                            frame_start <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= run ? ST_RUN : ST_STOPPING;
                        if (h_cnt == H_LAST) begin
                            h_cnt <= '0;
                            v_cnt <= v_cnt + 1'b1;
                        end else begin
                            h_cnt <= h_cnt + 1'b1;
                        end
                        if (in_win0) addr_cnt <= addr_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
            addrX <= '0;
            en    <= EN_HOLD;
        end else begin
            addrX <= addr_cnt;
            en    <= in_win0 ? EN_READ : EN_HOLD;
        end
    end

    sig_delay #(
        .WIDTH (4),
        .DEPTH (1 + RAM_LAT)
    ) u_align (
        .clkq (clkq),
        .rstn (rstn),
        .d    ({de0, hs0, vs0, in_win0}),
        .q    (aligned)
    );

    assign {de, hsync, vsync, pix_valid} = aligned;

endmodule

// File: tb/tb_img_scan_ctrl.sv
// Self-checking bench for img_scan_ctrl on a reduced panel geometry so whole frames stay short.
`timescale 1ns/1ps
module tb_img_scan_ctrl;

    localparam int HA = 24, HFP = 3, HS = 4, HBP = 3;
    localparam int VA = 14, VFP = 2, VS = 2, VBP = 2;
    localparam int IW = 8, IH = 5, RL = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int XMAX = HA - IW;
    localparam int YMAX = VA - IH;

    logic        clkq = 1'b0;
    logic        rstn = 1'b1;
    logic        run = 1'b0;
    logic [9:0]  win_x = '0;
    logic [9:0]  win_y = '0;
    logic [15:0] addrX;
    logic [1:0]  en;
    logic        de, hsync, vsync, pix_valid, frame_start;

    int checks = 0;
    int errors = 0;

    img_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .RAM_LAT(RL)
    ) dut (
        .clkq(clkq), .rstn(rstn), .run(run), .win_x(win_x), .win_y(win_y),
        .addrX(addrX), .en(en), .de(de), .hsync(hsync), .vsync(vsync),
        .pix_valid(pix_valid), .frame_start(frame_start)
    );

    always #5 clkq = ~clkq;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position as a single raster index, outputs derived arithmetically.
    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        win;
        logic [15:0] addr;
    } s0_t;

    function automatic s0_t stage0(input bit scan, input int pos, input int sx, input int sy);
        s0_t r;
        int h, v, n;
        r = '0;
        h = pos % HT;
        v = pos / HT;
        if (scan) begin
            r.de  = (h < HA) && (v < VA);
            r.hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
            r.vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
            r.win = (h >= sx) && (h < sx + IW) && (v >= sy) && (v < sy + IH);
            if (v < sy) n = 0;
            else if (v >= sy + IH) n = IW * IH;
            else n = (v - sy) * IW + ((h < sx) ? 0 : (h >= sx + IW) ? IW : (h - sx));
            r.addr = 16'(n);
        end
        return r;
    endfunction

    function automatic int clampi(input int c, input int lim);
        return (c > lim) ? lim : c;
    endfunction

    bit  m_scan = 1'b0;
    bit  m_fs = 1'b0;
    int  m_pos = 0;
    int  m_sx = 0;
    int  m_sy = 0;
    s0_t hist [RL+1] = '{default: '0};

    always @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
            m_scan <= 1'b0;
            m_fs   <= 1'b0;
            m_pos  <= 0;
            m_sx   <= 0;
            m_sy   <= 0;
            for (int i = 0; i <= RL; i++) hist[i] <= '0;
        end else begin
            for (int i = 1; i <= RL; i++) hist[i] <= hist[i-1];
            hist[0] <= stage0(m_scan, m_pos, m_sx, m_sy);
            m_fs <= 1'b0;
            if (!m_scan) begin
                if (run) begin
                    m_scan <= 1'b1;
                    m_pos  <= 0;
                    m_fs   <= 1'b1;
                    m_sx   <= clampi(int'(win_x), XMAX);
                    m_sy   <= clampi(int'(win_y), YMAX);
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos <= 0;
                m_sx  <= clampi(int'(win_x), XMAX);
                m_sy  <= clampi(int'(win_y), YMAX);
                if (run) m_fs <= 1'b1;
                else m_scan <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clkq) begin
        check("cycle", {en, addrX, de, hsync, vsync, pix_valid, frame_start},
              {(hist[0].win ? 2'b01 : 2'b00), hist[0].addr,
               hist[RL].de, hist[RL].hs, hist[RL].vs, hist[RL].win, m_fs});
    end

    // Called at a negedge with rstn=1, run=1, DUT idle and window (0,0).
    task automatic start_check(input string tag);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clkq);
            check({tag, "_fs"}, frame_start, (k == 1) ? 1 : 0);
            check({tag, "_en"}, en, (k >= 2) ? 1 : 0);
            check({tag, "_pv"}, pix_valid, (k >= 2 + RL) ? 1 : 0);
            if (k >= 2) check({tag, "_addr"}, addrX, k - 2);
        end
    endtask

    task automatic one_frame(input int wx, input int wy, output int f_pos, output int l_pos,
                             output int n, output int f_addr, output int l_addr);
        win_x = 10'(wx);
        win_y = 10'(wy);
        run = 1'b1;
        f_pos = -1; l_pos = -1; n = 0; f_addr = -1; l_addr = -1;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clkq);
            if (k == 1) run = 1'b0;
            if (en == 2'b01) begin
                if (f_pos < 0) begin
                    f_pos  = k - 2;
                    f_addr = int'(addrX);
                end
                l_pos  = k - 2;
                l_addr = int'(addrX);
                n++;
            end
        end
    endtask

    typedef struct { int wx; int wy; int sx; int sy; } win_vec_t;
    win_vec_t tbl [7];

    initial begin
        int  f_pos, l_pos, n, f_addr, l_addr;
        int  hs_hi, vs_hi, de_hi, runs, run_len, min_run, max_run, fs_seen;
        bit  found, prev, last_vs;
        int  fs_q[$];

        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{10, 3, 10, 3};
        tbl[2] = '{16, 9, 16, 9};
        tbl[3] = '{17, 10, 16, 9};
        tbl[4] = '{1023, 1023, 16, 9};
        tbl[5] = '{5, 9, 5, 9};
        tbl[6] = '{16, 0, 16, 0};

        #2 rstn = 1'b0;
        repeat (3) @(negedge clkq);
        check("reset", {en, addrX, de, hsync, vsync, pix_valid, frame_start}, 0);

        // First frame after reset with window at the origin.
        win_x = 0; win_y = 0; run = 1'b1; rstn = 1'b1;
        start_check("start");

        // Panel timing over one frame, starting at a vsync rising edge.
        found = 1'b0;
        prev = vsync;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clkq);
            if (vsync && !prev) found = 1'b1;
            else prev = vsync;
        end
        check("vs_found", found, 1);
        if (found) begin
            hs_hi = 0; vs_hi = 0; de_hi = 0; runs = 0; run_len = 0;
            min_run = 1 << 30; max_run = 0; last_vs = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                if (hsync) hs_hi++;
                if (vsync) vs_hi++;
                if (de) de_hi++;
                if (hsync) run_len++;
                else if (run_len > 0) begin
                    runs++;
                    if (run_len < min_run) min_run = run_len;
                    if (run_len > max_run) max_run = run_len;
                    run_len = 0;
                end
                last_vs = vsync;
                @(negedge clkq);
            end
            check("hs_high", hs_hi, HS * VT);
            check("vs_high", vs_hi, VS * HT);
            check("de_count", de_hi, HA * VA);
            check("hs_lines", runs, VT);
            check("hs_min_w", min_run, HS);
            check("hs_max_w", max_run, HS);
            check("vs_period", {last_vs, vsync}, 2'b01);
        end

        // Stop mid-frame: the frame completes, no new frame, outputs drain to zero.
        run = 1'b0;
        fs_seen = 0;
        for (int i = 0; i < FRAME + RL + 4; i++) begin
            @(negedge clkq);
            if (frame_start) fs_seen++;
        end
        check("stop_no_fs", fs_seen, 0);
        check("stop_drain", {en, addrX, de, hsync, vsync, pix_valid}, 0);

        // Window placement and clamping, one frame per vector.
        for (int t = 0; t < 7; t++) begin
            one_frame(tbl[t].wx, tbl[t].wy, f_pos, l_pos, n, f_addr, l_addr);
            check("win_first", f_pos, tbl[t].sy * HT + tbl[t].sx);
            check("win_last", l_pos, (tbl[t].sy + IH - 1) * HT + tbl[t].sx + IW - 1);
            check("win_reads", n, IW * IH);
            check("win_addr0", f_addr, 0);
            check("win_addrN", l_addr, IW * IH - 1);
        end

        // A short run=0 pulse inside a frame must not break the frame sequence.
        win_x = 3; win_y = 2; run = 1'b1;
        fs_q.delete();
        for (int k = 1; k <= 2 * FRAME + 2; k++) begin
            @(negedge clkq);
            if (k == 100) run = 1'b0;
            if (k == 150) run = 1'b1;
            if (frame_start) fs_q.push_back(k);
        end
        check("pulse_fs_count", fs_q.size(), 3);
        if (fs_q.size() == 3) begin
            check("pulse_fs0", fs_q[0], 1);
            check("pulse_fs1", fs_q[1], 1 + FRAME);
            check("pulse_fs2", fs_q[2], 1 + 2 * FRAME);
        end

        // Asynchronous reset in the middle of the active area, then restart.
        repeat (8 * HT + 10) @(negedge clkq);
        check("pre_rst_de", de, 1);
        #2 rstn = 1'b0;
        #1 check("async_rst", {en, addrX, de, hsync, vsync, pix_valid, frame_start}, 0);
        win_x = 0; win_y = 0;
        @(negedge clkq);
        rstn = 1'b1;
        start_check("restart");

        // Random run toggling, window moves and occasional resets against the model.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clkq);
            if (run ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 49) == 0)) run = ~run;
            if ($urandom_range(0, 299) == 0) begin
                win_x = 10'($urandom_range(0, 30));
                win_y = 10'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 199) == 0) win_x = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3999) == 0) begin
                #2 rstn = 1'b0;
                @(negedge clkq);
                rstn = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
